// File: rtl/eco32f_itlb.sv
// Instruction-side TLB: 32 fully-associative entries, zero-latency fetch lookup,
// random replacement counter and a maintenance port for writes, reads and probes.
module eco32f_itlb #(
    parameter int NUM_FIXED = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] itlb_va,
    output logic [31:0] itlb_pa,
    output logic        itlb_kmiss,
    output logic        itlb_umiss,
    output logic        itlb_invalid,
    input  logic [1:0]  tlb_op,
    input  logic [4:0]  tlb_index,
    input  logic [31:0] tlb_entry_hi,
    input  logic [31:0] tlb_entry_lo,
    output logic [31:0] tlb_rd_hi,
    output logic [31:0] tlb_rd_lo,
    output logic [4:0]  tlb_random,
    output logic        tlb_probe_done,
    output logic [31:0] tlb_probe_result
);

    typedef enum logic {
        IDLE,
        PROBE
    } probe_state_t;

    localparam logic [1:0] OP_WRITE_IDX  = 2'b01;
    localparam logic [1:0] OP_WRITE_RAND = 2'b10;
    localparam logic [1:0] OP_PROBE      = 2'b11;

    logic [19:0] vpn [32];
    logic [19:0] pfn [32];
    logic [31:0] w;
    logic [31:0] v;

    probe_state_t state;
    logic [19:0]  probe_vpn;

    logic        wr_en;
    logic [4:0]  wr_idx;
    logic        direct;
    logic        hit;
    logic [4:0]  hit_idx;
    logic        probe_hit;
    logic [4:0]  probe_idx;
    logic        unused_bits;

    assign unused_bits = ^{tlb_entry_hi[11:0], tlb_entry_lo[11:2]};

    assign wr_en  = (tlb_op == OP_WRITE_IDX) || (tlb_op == OP_WRITE_RAND);
    assign wr_idx = (tlb_op == OP_WRITE_RAND) ? tlb_random : tlb_index;

    // Entry storage; reset VPNs all sit in the unmapped region so nothing can hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                vpn[i] <= 20'hC0000;
                pfn[i] <= 20'h00000;
            end
            w <= '0;
            v <= '0;
        end else if (wr_en) begin
            vpn[wr_idx] <= tlb_entry_hi[31:12];
            pfn[wr_idx] <= tlb_entry_lo[31:12];
            w[wr_idx]   <= tlb_entry_lo[1];
            v[wr_idx]   <= tlb_entry_lo[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlb_random <= 5'd31;
        end else if (tlb_random == 5'(NUM_FIXED)) begin
            tlb_random <= 5'd31;
        end else begin
            tlb_random <= tlb_random - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlb_rd_hi <= 32'hC000_0000;
            tlb_rd_lo <= 32'h0;
        end else begin
            tlb_rd_hi <= {vpn[tlb_index], 12'h000};
            tlb_rd_lo <= {pfn[tlb_index], 10'b0, w[tlb_index], v[tlb_index]};
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = 5'd0;
        probe_hit = 1'b0;
        probe_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vpn[i] == itlb_va[31:12]) begin
                hit     = 1'b1;
                hit_idx = 5'(i);
            end
            if (vpn[i] == probe_vpn) begin
                probe_hit = 1'b1;
                probe_idx = 5'(i);
            end
        end
    end

    assign direct = (itlb_va[31:30] == 2'b11);

    always_comb begin
        itlb_kmiss   = 1'b0;
        itlb_umiss   = 1'b0;
        itlb_invalid = 1'b0;
        if (direct) begin
            itlb_pa = {2'b00, itlb_va[29:0]};
        end else if (hit) begin
            itlb_pa      = {pfn[hit_idx], itlb_va[11:0]};
            itlb_invalid = ~v[hit_idx];
        end else begin
            itlb_pa    = {pfn[0], itlb_va[11:0]};
            itlb_kmiss = itlb_va[31];
            itlb_umiss = ~itlb_va[31];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            probe_vpn        <= 20'h00000;
            tlb_probe_done   <= 1'b0;
            tlb_probe_result <= 32'h0;
        end else begin
            tlb_probe_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tlb_op == OP_PROBE) begin
                        probe_vpn <= tlb_entry_hi[31:12];
                        state     <= PROBE;
                    end
                end
                PROBE: begin
                    tlb_probe_result <= {~probe_hit, 26'b0, probe_idx};
                    tlb_probe_done   <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eco32f_itlb.sv
// Directed bench for eco32f_itlb: lookup regions, writes, readback, random counter and probe.
module tb_eco32f_itlb;

    logic        clk;
    logic        rst;
    logic [31:0] itlb_va;
    logic [31:0] itlb_pa;
    logic        itlb_kmiss;
    logic        itlb_umiss;
    logic        itlb_invalid;
    logic [1:0]  tlb_op;
    logic [4:0]  tlb_index;
    logic [31:0] tlb_entry_hi;
    logic [31:0] tlb_entry_lo;
    logic [31:0] tlb_rd_hi;
    logic [31:0] tlb_rd_lo;
    logic [4:0]  tlb_random;
    logic        tlb_probe_done;
    logic [31:0] tlb_probe_result;

    int checks = 0;
    int errors = 0;

    eco32f_itlb #(.NUM_FIXED(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .itlb_va          (itlb_va),
        .itlb_pa          (itlb_pa),
        .itlb_kmiss       (itlb_kmiss),
        .itlb_umiss       (itlb_umiss),
        .itlb_invalid     (itlb_invalid),
        .tlb_op           (tlb_op),
        .tlb_index        (tlb_index),
        .tlb_entry_hi     (tlb_entry_hi),
        .tlb_entry_lo     (tlb_entry_lo),
        .tlb_rd_hi        (tlb_rd_hi),
        .tlb_rd_lo        (tlb_rd_lo),
        .tlb_random       (tlb_random),
        .tlb_probe_done   (tlb_probe_done),
        .tlb_probe_result (tlb_probe_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] idx,
                                 input logic [31:0] hi, input logic [31:0] lo);
        tlb_op       = op;
        tlb_index    = idx;
        tlb_entry_hi = hi;
        tlb_entry_lo = lo;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkLookup(input string tag, input logic [31:0] va, input logic [31:0] pa,
                               input logic km, input logic um, input logic inv);
        itlb_va = va;
        #1;
        checkOutput({tag, "_pa"}, itlb_pa, pa);
        checkOutput({tag, "_flags"}, {29'b0, itlb_kmiss, itlb_umiss, itlb_invalid}, {29'b0, km, um, inv});
    endtask

    task automatic writeEntry(input logic [4:0] idx, input logic [31:0] hi, input logic [31:0] lo);
        applyStimulus(2'b01, idx, hi, lo);
        tick();
        applyStimulus(2'b00, idx, 32'h0, 32'h0);
    endtask

    task automatic runProbe(input string tag, input logic [31:0] hi, input logic [31:0] exp);
        applyStimulus(2'b11, 5'd0, hi, 32'h0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput({tag, "_early"}, {31'b0, tlb_probe_done}, 32'd0);
        tick();
        checkOutput({tag, "_done"}, {31'b0, tlb_probe_done}, 32'd1);
        checkOutput({tag, "_result"}, tlb_probe_result, exp);
        tick();
        checkOutput({tag, "_pulse_end"}, {31'b0, tlb_probe_done}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        itlb_va = 32'h0;
        applyStimulus(2'b00, 5'd0, 32'h0, 32'h0);
        repeat (2) tick();

        checkOutput("rst_rd_hi", tlb_rd_hi, 32'hC000_0000);
        checkOutput("rst_rd_lo", tlb_rd_lo, 32'h0);
        checkOutput("rst_random", {27'b0, tlb_random}, 32'd31);
        checkOutput("rst_done", {31'b0, tlb_probe_done}, 32'd0);
        checkOutput("rst_result", tlb_probe_result, 32'h0);

        rst = 1'b0;
        // Counter walks 31 down to 4 (28 values) and then wraps to 31.
        for (int i = 0; i <= 28; i++) begin
            checkOutput($sformatf("random_%0d", i), {27'b0, tlb_random},
                        (i < 28) ? 32'(31 - i) : 32'd31);
            tick();
        end

        checkLookup("direct", 32'hE000_1234, 32'h2000_1234, 1'b0, 1'b0, 1'b0);
        checkLookup("umiss", 32'h0000_1000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        checkLookup("kmiss", 32'h8000_1000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        applyStimulus(2'b01, 5'd5, 32'h0040_0000, 32'h1234_5003);
        checkLookup("wr5_same", 32'h0040_0ABC, 32'h0000_0ABC, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(2'b00, 5'd5, 32'h0, 32'h0);
        checkLookup("wr5_next", 32'h0040_0ABC, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rd5_hi", tlb_rd_hi, 32'h0040_0000);
        checkOutput("rd5_lo", tlb_rd_lo, 32'h1234_5003);

        writeEntry(5'd7, 32'h8000_2000, 32'h5555_5000);
        checkLookup("inv7", 32'h8000_2010, 32'h5555_5010, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 40 && tlb_random != 5'd9; n++) tick();
        checkOutput("rand_reach9", {27'b0, tlb_random}, 32'd9);
        applyStimulus(2'b10, 5'd0, 32'h00AB_C000, 32'h0BEE_F003);
        tick();
        applyStimulus(2'b00, 5'd9, 32'h0, 32'h0);
        tick();
        checkOutput("rd9_hi", tlb_rd_hi, 32'h00AB_C000);
        checkOutput("rd9_lo", tlb_rd_lo, 32'h0BEE_F003);
        checkLookup("hit9", 32'h00AB_C123, 32'h0BEE_F123, 1'b0, 1'b0, 1'b0);

        runProbe("probe5", 32'h0040_0000, 32'h0000_0005);
        runProbe("probe_miss", 32'h1234_5000, 32'h8000_0000);

        writeEntry(5'd10, 32'h0700_0000, 32'hAAAA_A003);
        writeEntry(5'd3, 32'h0700_0000, 32'h3333_3003);
        runProbe("probe_dup", 32'h0700_0000, 32'h0000_0003);
        checkLookup("dup_lookup", 32'h0700_0ABC, 32'h3333_3ABC, 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b11, 5'd0, 32'h0040_0000, 32'h0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        checkOutput("rstprobe_done", {31'b0, tlb_probe_done}, 32'd0);
        checkOutput("rstprobe_result", tlb_probe_result, 32'h0);
        rst = 1'b0;
        checkOutput("rstprobe_random", {27'b0, tlb_random}, 32'd31);
        checkLookup("rstprobe_l5", 32'h0040_0ABC, 32'h0000_0ABC, 1'b0, 1'b1, 1'b0);
        checkLookup("rstprobe_l3", 32'h0700_0ABC, 32'h0000_0ABC, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("rstprobe_after", {31'b0, tlb_probe_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eco32f_itlb.md
# eco32f_itlb

Instruction-side translation lookaside buffer for the eco32f core. It sits directly upstream of the fetch unit and translates the fetch virtual address `itlb_va` into `itlb_pa` within the same cycle. It flags kernel/user misses and invalid entries. The block owns 32 fully-associative entries, a random-replacement counter, and a maintenance port that the execute stage drives for indexed write, random write, read and probe.

## Interface
- `NUM_FIXED`, 4: entries 0..NUM_FIXED-1 are never selected by the random counter.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `itlb_va` in 32: fetch virtual address.
- `itlb_pa` out 32: translated physical address (combinational).
- `itlb_kmiss` out 1: no matching entry, VA[31:30]==2'b10.
- `itlb_umiss` out 1: no matching entry, VA[31]==0.
- `itlb_invalid` out 1: matching entry has V=0.
- `tlb_op` in 2: 00 none, 01 write-indexed, 10 write-random, 11 probe.
- `tlb_index` in 5: entry for write-indexed and for read.
- `tlb_entry_hi` in 32: VPN in [31:12]; also the probe VA.
- `tlb_entry_lo` in 32: PFN [31:12], W bit 1, V bit 0.
- `tlb_rd_hi` out 32: registered hi word of entry `tlb_index`.
- `tlb_rd_lo` out 32: registered lo word of entry `tlb_index`.
- `tlb_random` out 5: current random counter.
- `tlb_probe_done` out 1: one-cycle pulse, probe result valid.
- `tlb_probe_result` out 32: bit31=miss; [4:0] = hit index.

## Operation
- Entry storage: vpn[19:0], pfn[19:0], w, v per entry.
- Reset values: vpn=20'hC0000, pfn=0, w=0, v=0.
- Direct-mapped region: VA[31:30]==2'b11.
  - `itlb_pa` = {2'b00, VA[29:0]}.
  - All three flags are 0.
  - Entries are ignored.
- Mapped region: compare VA[31:12] against all 32 vpn fields.
  - Lowest matching index wins.
  - Hit: `itlb_pa` = {pfn, VA[11:0]}; `itlb_invalid` = !v.
  - Miss: `itlb_pa` = {pfn_of_entry0, VA[11:0]} (don't-care value, but deterministic); `itlb_kmiss` = VA[31], `itlb_umiss` = !VA[31].
- After reset, no mapped VA can hit, because every reset vpn lies in the direct-mapped region.
- Random counter:
  - 5 bits, reset 31.
  - Decrements every clock.
  - When at NUM_FIXED, loads 31 next.
  - Never holds a value below NUM_FIXED.
- Write-indexed (`tlb_op`=01): entry[`tlb_index`] takes hi[31:12], lo[31:12], lo[1], lo[0] at the clock edge.
- Write-random (`tlb_op`=10): same update, targeting entry[`tlb_random`] as sampled at that edge.
- Read: every cycle, `tlb_rd_hi` <= {vpn,12'b0} and `tlb_rd_lo` <= {pfn,10'b0,w,v} of entry[`tlb_index`].
- Probe (`tlb_op`=11), two-state FSM, IDLE -> PROBE -> IDLE:
  - IDLE: sample `tlb_entry_hi`[31:12] into a probe register.
  - PROBE: compare the probe register against all entries, lowest match wins, with no region exemption.
  - Result: bit31 = no match, [4:0] = index (0 on miss), [30:5] = 0.
  - `tlb_probe_done` pulses in the cycle the result register updates.
  - A probe op issued while in PROBE is ignored.
- Write ops issued while in PROBE still execute. The probe compares against contents as of the PROBE cycle.

## Timing
- Lookup: purely combinational from `itlb_va` and entry state, with zero latency. The fetch path depends on `itlb_pa[4:2]` in the same cycle.
- Writes become visible to lookup and probe the cycle after the op edge. A same-cycle lookup sees old contents.
- Read data lags `tlb_index` by one cycle.
- Probe request at edge N:
  - `tlb_probe_done`=1 and the result are valid after edge N+1.
  - The done pulse lasts exactly one cycle.
- Reset values of outputs:
  - `tlb_rd_hi`=32'hC0000000, `tlb_rd_lo`=0.
  - `tlb_random`=31.
  - `tlb_probe_done`=0, `tlb_probe_result`=0.
  - FSM=IDLE.
- Reset asserted mid-probe: FSM returns to IDLE and no done pulse is produced.
- The random counter keeps running during stalls; no stall input exists.

## Test plan
- Reset, `itlb_va`=E0001234 -> `itlb_pa`=20001234, kmiss=umiss=invalid=0. `itlb_va`=00001000 -> umiss=1. `itlb_va`=80001000 -> kmiss=1.
- Write-indexed idx 5, hi=00400000, lo=12345003:
  - Same-cycle lookup of 00400ABC -> umiss=1.
  - Next cycle -> pa=12345ABC, all flags 0.
  - Read idx 5 -> rd_lo=12345003.
- Write-indexed idx 7, hi=80002000, lo=55555000 (V=0) -> lookup 80002010 gives invalid=1, kmiss=0, pa=55555010.
- Random counter:
  - After reset, observe 31, 30 ... 4, 31 over 28 cycles.
  - Write-random when `tlb_random`=9 -> entry 9 updated, read back matches.
- Probe:
  - hi=00400000 after the idx-5 write -> done pulse one cycle later, result=00000005.
  - Probe 12345000 -> result=80000000.
  - Two entries with equal VPN at idx 3 and 10 -> result=3.
- Assert `rst` in the PROBE cycle -> no done pulse, `tlb_random`=31, mapped lookups miss.
